// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr
// Registered N-way arbiter with a locked grant that is held until the winner
// drops its request. mode selects fixed priority (highest index wins) or
// round-robin rotation starting just below the last winner.
//
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to HOLD_MAX
// cycles. This adds a hold counter and a one-cycle 'timeout' output pulse on
// every forced revoke. Without the macro, a grant is held indefinitely and the
// 'timeout' port does not exist.

module prio_arbiter_rr #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    // Reject illegal parameter sets at elaboration time.
    if ((N < 2) || (IDXW != $clog2(N)) || (HOLD_MAX < 2)) begin : g_bad_param
        $error("prio_arbiter_rr: need N>=2, IDXW==clog2(N), HOLD_MAX>=2");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Winner selection.
    // mode 0: highest set index.
    // mode 1: descending scan starting at ptr-1 and wrapping, ending at ptr.
    function automatic logic [IDXW-1:0] pick(
        input logic [N-1:0]    r,
        input logic            m,
        input logic [IDXW-1:0] p
    );
        logic [IDXW-1:0] w;
        logic            found;
        int              pos;
        w     = {IDXW{1'b0}};
        found = 1'b0;
        pos   = 0;
        if (m == 1'b0) begin
            // Ascending overwrite leaves the highest set index in w.
            for (int i = 0; i < N; i++) begin
                if (r[IDXW'(i)]) begin
                    w = IDXW'(i);
                end else begin
                    w = w;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                pos = (int'(p) + N - k) % N;
                if (!found && r[IDXW'(pos)]) begin
                    w     = IDXW'(pos);
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
        return w;
    endfunction

    // Binary index to one-hot vector. Indices are always below N.
    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] i);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [N-1:0]    masked_s;   // requests with the current owner removed
    logic [IDXW-1:0] win_s;      // winner of the decision taken this cycle
    logic            hold_s;     // owner keeps the grant this cycle
    logic            expire_s;   // owner is forcibly revoked this cycle

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // The owner is revoked once it has held the grant for HOLD_MAX cycles.
    always_comb begin
        expire_s = (state_q == ST_GRANT) && req[idx_q] &&
                   (cnt_q == CNTW'(HOLD_MAX - 1));
    end

    // Hold counter: counts held cycles, restarts on every other outcome.
    always_comb begin
        cnt_d     = {CNTW{1'b0}};
        timeout_d = expire_s;
        if (hold_s) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNTW{1'b0}};
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= {CNTW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // Without the timeout feature a grant is never revoked.
    always_comb begin
        expire_s = 1'b0;
    end
`endif

    // Ownership qualifiers used by the next-state logic.
    always_comb begin
        masked_s = req & ~onehot(idx_q);
        hold_s   = (state_q == ST_GRANT) && req[idx_q] && !expire_s;
    end

    // Next-state and registered-output logic of the arbiter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        win_s   = {IDXW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (req != {N{1'b0}}) begin
                    win_s   = pick(req, mode, ptr_q);
                    state_d = ST_GRANT;
                    gnt_d   = onehot(win_s);
                    idx_d   = win_s;
                    valid_d = 1'b1;
                    ptr_d   = win_s;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = {N{1'b0}};
                    idx_d   = {IDXW{1'b0}};
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (hold_s) begin
                    state_d = ST_GRANT;
                end else if (masked_s != {N{1'b0}}) begin
                    // Back-to-back handoff; the old owner sits out this decision.
                    win_s   = pick(masked_s, mode, ptr_q);
                    state_d = ST_GRANT;
                    gnt_d   = onehot(win_s);
                    idx_d   = win_s;
                    valid_d = 1'b1;
                    ptr_d   = win_s;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = {N{1'b0}};
                    idx_d   = {IDXW{1'b0}};
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N{1'b0}};
                idx_d   = {IDXW{1'b0}};
                valid_d = 1'b0;
                ptr_d   = {IDXW{1'b0}};
            end
        endcase
    end

    // State, grant, and round-robin pointer registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= {N{1'b0}};
            idx_q   <= {IDXW{1'b0}};
            valid_q <= 1'b0;
            ptr_q   <= {IDXW{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Testbench for prio_arbiter_rr. A behavioural reference model predicts the
// outputs for every driven cycle. The prediction is queued when the stimulus
// is applied and compared when the registered outputs appear.
// Directed checks cover the specific scenarios of interest. A random phase
// follows the directed checks.

module tb_prio_arbiter_rr;

    localparam int N    = 8;
    localparam int IDXW = 3;
`ifdef ARB_TIMEOUT_EN
    localparam int HM   = 4;
`else
    localparam int HM   = 16;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic            timeout;
`endif

    prio_arbiter_rr #(
        .N        (N),
        .IDXW     (IDXW),
        .HOLD_MAX (HM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    gnt;
        logic [IDXW-1:0] idx;
        logic            valid;
        logic            to;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: owner (-1 = idle), rotation pointer, hold count.
    int m_g   = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_to  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int ref_pick(input logic [N-1:0] r, input logic m, input int p);
        if (m == 1'b0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int s = 1; s <= N; s++) begin
                int j;
                j = p - s;
                if (j < 0) j = j + N;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic r_mode, input logic [N-1:0] r_req);
        logic [N-1:0] rest;
        bit           held;
        bit           expire;
        int           w;
        m_to = 1'b0;
        if (r_rst) begin
            m_g   = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else if (m_g < 0) begin
            if (r_req != '0) begin
                w     = ref_pick(r_req, r_mode, m_ptr);
                m_g   = w;
                m_ptr = w;
                m_cnt = 0;
            end
        end else begin
            held   = r_req[m_g];
            expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
            expire = held && (m_cnt == HM - 1);
`endif
            if (held && !expire) begin
                m_cnt = m_cnt + 1;
            end else begin
                rest        = r_req;
                rest[m_g]   = 1'b0;
                m_to        = expire;
                m_cnt       = 0;
                if (rest != '0) begin
                    w     = ref_pick(rest, r_mode, m_ptr);
                    m_g   = w;
                    m_ptr = w;
                end else begin
                    m_g = -1;
                end
            end
        end
    endtask

    // One clock cycle: drive, predict, enqueue, then compare at edge + 1.
    task automatic step(input logic r_rst, input logic r_mode, input logic [N-1:0] r_req);
        exp_t e;
        rst  = r_rst;
        mode = r_mode;
        req  = r_req;
        model_step(r_rst, r_mode, r_req);
        e.gnt   = (m_g < 0) ? '0 : (N'(1) << m_g);
        e.idx   = (m_g < 0) ? '0 : IDXW'(m_g);
        e.valid = (m_g >= 0);
        e.to    = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
`ifdef ARB_TIMEOUT_EN
        chk("timeout",   32'(timeout),   32'(e.to));
`endif
    endtask

    int rr_exp [8] = '{6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        int cur;
        logic [N-1:0] r;
        rst  = 1'b1;
        mode = 1'b0;
        req  = '0;
        @(posedge clk);
        #1;

        // Reset with all requests high, then fixed-priority first grant.
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        step(1'b0, 1'b0, 8'hFF);
        chk("prio_gnt", 32'(gnt), 32'h80);
        chk("prio_idx", 32'(gnt_idx), 32'd7);

        // Lock then handoff without an idle gap.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h05);
        chk("lock_first", 32'(gnt_idx), 32'd2);
        step(1'b0, 1'b0, 8'h85);
        chk("lock_hold", 32'(gnt_idx), 32'd2);
        step(1'b0, 1'b0, 8'h80);
        chk("handoff_idx", 32'(gnt_idx), 32'd7);
        chk("handoff_valid", 32'(gnt_valid), 32'h1);

        // Round-robin rotation from reset, each winner dropping after its grant.
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        chk("rr_first", 32'(gnt_idx), 32'd7);
        cur = 7;
        for (int k = 0; k < 8; k++) begin
            r      = 8'hFF;
            r[cur] = 1'b0;
            step(1'b0, 1'b1, r);
            chk("rr_seq", 32'(gnt_idx), 32'(rr_exp[k]));
            cur = rr_exp[k];
        end

        // Single request released back to idle.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h01);
        chk("rel_gnt", 32'(gnt), 32'h01);
        step(1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        chk("rel_gnt_off", 32'(gnt), 32'h00);
        chk("rel_valid_off", 32'(gnt_valid), 32'h0);

        // Reset in the middle of a grant, then confirm the pointer restarted.
        step(1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h20);
        step(1'b1, 1'b0, 8'h20);
        chk("midrst_gnt", 32'(gnt), 32'h00);
        step(1'b0, 1'b1, 8'h21);
        chk("midrst_ptr", 32'(gnt_idx), 32'd5);

        // Mode change while a grant is held has no effect until release.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h0C);
        step(1'b0, 1'b1, 8'h0C);
        chk("mode_hold", 32'(gnt_idx), 32'd3);
        step(1'b0, 1'b1, 8'h04);
        chk("mode_handoff", 32'(gnt_idx), 32'd2);
        step(1'b0, 1'b0, 8'h00);

`ifdef ARB_TIMEOUT_EN
        // Forced revoke with another requester waiting.
        step(1'b0, 1'b0, 8'h09);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'h09);
            chk("to_hold", 32'(gnt_idx), 32'd3);
        end
        step(1'b0, 1'b0, 8'h09);
        chk("to_next", 32'(gnt_idx), 32'd0);
        chk("to_pulse", 32'(timeout), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        // Forced revoke with the owner alone: one idle cycle, then re-grant.
        step(1'b0, 1'b0, 8'h08);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'h08);
        end
        step(1'b0, 1'b0, 8'h08);
        chk("to_idle", 32'(gnt_valid), 32'h0);
        step(1'b0, 1'b0, 8'h08);
        chk("to_regrant", 32'(gnt_idx), 32'd3);
`else
        // Without the timeout feature a grant is held indefinitely.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 8'h09);
        end
        chk("hold_long", 32'(gnt_idx), 32'd3);
`endif
        step(1'b0, 1'b0, 8'h00);

        // Random traffic with occasional resets, checked against the model.
        for (int k = 0; k < 400; k++) begin
            r = N'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r = '0;
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), r);
        end
        step(1'b0, 1'b0, 8'h00);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prio_arbiter_rr.md
Name: prio_arbiter_rr

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Arbitrates N request lines and issues a locked grant that is held until the winner drops its request.
- Selectable priority mode:
  - fixed: highest index wins, same as the existing encoder;
  - round-robin: fair rotation.
- Outputs one-hot grant, binary index and valid; sits in front of shared resources (bus, memory port).

Parameters:
- N, 8, number of request channels (N >= 2).
- IDXW, 3, index width; must equal clog2(N).
- HOLD_MAX, 16, timeout in cycles; used only when ARB_TIMEOUT_EN is defined (HOLD_MAX >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  N  request lines; a channel keeps its bit high for as long as it wants the grant.
- gnt  output  N  registered one-hot grant; all zeros when idle.
- gnt_idx  output  IDXW  registered binary index of the granted channel; 0 when idle.
- gnt_valid  output  1  high while any grant is active (equals OR of gnt).
- timeout  output  1  one-cycle pulse on a forced revoke; exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at clock edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0;
  - state=IDLE; RR pointer ptr=0; hold counter=0.
  - Reset overrides everything, including a grant in progress: outputs are zero in the cycle after the reset edge.
- States: IDLE, GRANT.
- Arbitration function pick(req, mode, ptr):
  - mode=0: highest set index of req.
  - mode=1: scan indices ptr-1, ptr-2, ..., 0, N-1, ..., ptr (descending, wrapping, modulo N); first set bit wins.
  - After reset (ptr=0) the scan starts at N-1, so both modes pick identically.
  - mode is sampled only at the edge where an arbitration decision is taken; changing it during GRANT has no effect until the next decision.
- IDLE:
  - req==0: stay in IDLE, outputs stay 0.
  - req!=0: at the next edge gnt=onehot(w), gnt_idx=w, gnt_valid=1, ptr=w, go to GRANT, where w=pick(...).
  - Latency: request asserted in cycle t, grant visible in cycle t+1.
- GRANT (granted index g):
  - req[g]=1: hold the grant unchanged. Other requests arriving, leaving or changing never preempt.
  - req[g]=0 and (req with bit g cleared)!=0: at the next edge re-arbitrate with bit g cleared and grant the new winner. Back-to-back, no idle cycle. ptr is updated to the new winner.
  - req[g]=0 and all other bits 0: at the next edge clear gnt, gnt_idx and gnt_valid, and return to IDLE.
- Grant is never more than one-hot. gnt_valid is never 1 while gnt==0.
- Index arithmetic is modulo N; for non-power-of-2 N, indices >= N are never produced.
- Requests are not latched: a request pulse that drops before it is granted is lost.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each cycle in GRANT while req[g]=1.
  - When counter==HOLD_MAX-1 and req[g] is still 1, the next edge revokes g. Re-arbitration follows the req[g]=0 rule above (bit g masked for this one decision) and pulses timeout=1 for one cycle.
  - If only g is requesting, the grant goes to IDLE for one cycle, then re-grants g if it still requests.
  - A grant therefore lasts at most HOLD_MAX cycles.
- Undefined: no counter, no timeout port; a grant is held indefinitely.

Test Plan:
- Reset and priority: rst=1 for 2 cycles, req=8'hFF -> all outputs 0 during reset. After release, mode=0 -> gnt=8'h80, gnt_idx=7, valid=1 one cycle after req.
- Lock and handoff: mode=0, req=8'h05 -> gnt_idx=2. Then raise req[7] while req[2] is held -> gnt_idx stays 2. Then drop req[2] -> next cycle gnt_idx=7, no idle gap.
- Round-robin fairness: mode=1, req=8'hFF held, each winner drops its bit for one cycle after its grant -> grant sequence 7,6,5,4,3,2,1,0,7.
- Release to idle: single req=8'h01 then req=0 -> gnt=1, gnt_idx=0 for the held cycles, then gnt=0, valid=0 the cycle after the drop.
- Mid-operation reset and mode change:
  - rst pulsed during a grant to index 5 -> all outputs 0 next cycle, ptr=0.
  - mode toggled mid-grant -> grant unchanged until release.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h09 held -> idx 3 for 4 cycles, timeout pulse, then idx 0. With req=8'h08 only -> 4 cycles granted, 1 idle cycle, then re-granted.
